// File: rtl/health_monitor_scheduler_pkg.sv
// healthcare_pkg: shared definitions for the health monitor scheduler.
//   - channel index constants (sensorSel encoding)
//   - scheduler FSM state type
//   - alarm priority order and the alarmCode encoder
package healthcare_pkg;

  localparam int unsigned NUM_CH = 5;

  localparam logic [2:0] CH_PRESSURE = 3'd0;
  localparam logic [2:0] CH_BLOOD    = 3'd1;
  localparam logic [2:0] CH_TEMP     = 3'd2;
  localparam logic [2:0] CH_FALL     = 3'd3;
  localparam logic [2:0] CH_GLYCEMIC = 3'd4;

  localparam logic [2:0] ALARM_NONE  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_GAP
  } state_e;

  // Highest priority first.
  localparam logic [2:0] ALARM_PRIO [NUM_CH] = '{CH_FALL, CH_PRESSURE, CH_TEMP, CH_BLOOD, CH_GLYCEMIC};

  // Walk from lowest to highest priority so the highest set channel wins.
  function automatic logic [2:0] alarm_code(input logic [NUM_CH-1:0] vec);
    logic [2:0] code;
    code = ALARM_NONE;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (vec[ALARM_PRIO[i-1]]) code = ALARM_PRIO[i-1];
    end
    return code;
  endfunction

endpackage

// File: rtl/health_monitor_scheduler_persistence_filter.sv
// persistence_filter: per-channel glitch filter and latched alarm.
//   clk, rst_n       clock, async active-low reset
//   sample_valid_i   a transfer for this channel happens this cycle
//   abnormal_i       channel abnormal condition (meaningful with sample_valid_i)
//   ack_i            alarm acknowledge
//   alarm_o          latched alarm bit
// The counter saturates at PERSIST; an abnormal sample reaching PERSIST sets
// the alarm, which an ack clears only once the counter has dropped below it.
module persistence_filter #(
  parameter int unsigned PERSIST = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_valid_i,
  input  logic abnormal_i,
  input  logic ack_i,
  output logic alarm_o
);

  localparam logic [2:0] LIMIT = 3'(PERSIST);

  logic [2:0] cnt_q, cnt_d;
  logic       alarm_q, alarm_d;
  logic       set;

  always_comb begin
    cnt_d = cnt_q;
    if (sample_valid_i) begin
      if (!abnormal_i)         cnt_d = '0;
      else if (cnt_q < LIMIT)  cnt_d = cnt_q + 3'd1;
    end

    set     = sample_valid_i && abnormal_i && (cnt_d == LIMIT);
    alarm_d = alarm_q;
    if (set)                           alarm_d = 1'b1;
    else if (ack_i && (cnt_q < LIMIT)) alarm_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm_o = alarm_q;

endmodule

// File: rtl/health_monitor_scheduler.sv
// health_monitor_scheduler: round-robin scan of the five phase-1 health
// detectors over the sensorReq/sensorAck handshake, with per-channel
// persistence filtering, latched alarms and request timeout faults.
//   clk, rst_n                 clock, async active-low reset
//   enable                     run scanning
//   sensorReq/sensorSel        request and channel index (0..4)
//   sensorAck                  detector inputs valid; transfer = req && ack
//   *Abnormality, fallDetected detector flags, glycemicIndex 4-bit value
//   alarmAck                   single-cycle alarm acknowledge
//   alarmVector/alarmActive    latched alarms and their OR
//   alarmCode                  highest-priority alarm channel, 7 when none
//   sensorFault                per-channel timeout flags
//   glycemicLatched            last transferred glycemic index
//   scanDone                   one-cycle pulse at end of a round
module health_monitor_scheduler
  import healthcare_pkg::*;
#(
  parameter int unsigned PERSIST    = 3,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 8,
  parameter int unsigned GI_HIGH    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       sensorReq,
  output logic [2:0] sensorSel,
  input  logic       sensorAck,
  input  logic       presureAbnormality,
  input  logic       bloodAbnormality,
  input  logic       lowTempAbnormality,
  input  logic       highTempAbnormality,
  input  logic       fallDetected,
  input  logic [3:0] glycemicIndex,
  input  logic       alarmAck,
  output logic [4:0] alarmVector,
  output logic       alarmActive,
  output logic [2:0] alarmCode,
  output logic [4:0] sensorFault,
  output logic [3:0] glycemicLatched,
  output logic       scanDone
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [3:0]  GI_LIM   = 4'(GI_HIGH);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [2:0]  sel_q, sel_d;
  logic        done_q, done_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] gap_q, gap_d;
  logic [4:0]  fault_q, fault_d;
  logic [3:0]  gi_q, gi_d;

  logic        xfer, tmo, complete;
  logic [4:0]  hit;
  logic [4:0]  abn;
  logic [4:0]  alarm_vec;

  assign xfer     = req_q && sensorAck;
  assign tmo      = req_q && !sensorAck && (wait_q == TMO_LAST);
  assign complete = xfer || tmo;
  assign hit      = 5'b00001 << sel_q;

  assign abn[CH_PRESSURE] = presureAbnormality;
  assign abn[CH_BLOOD]    = bloodAbnormality;
  assign abn[CH_TEMP]     = lowTempAbnormality | highTempAbnormality;
  assign abn[CH_FALL]     = fallDetected;
  assign abn[CH_GLYCEMIC] = (glycemicIndex >= GI_LIM);

  // sensorReq is registered alongside the state, so it is high exactly
  // during SCAN and stays high across channel changes within a round.
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    sel_d   = sel_q;
    done_d  = 1'b0;
    wait_d  = wait_q;
    gap_d   = gap_q;

    case (state_q)
      ST_IDLE: begin
        sel_d  = '0;
        wait_d = '0;
        gap_d  = '0;
        if (enable) begin
          state_d = ST_SCAN;
          req_d   = 1'b1;
        end
      end
      ST_SCAN: begin
        req_d = 1'b1;
        if (complete) begin
          wait_d = '0;
          if (sel_q == CH_GLYCEMIC) begin
            done_d  = 1'b1;
            state_d = ST_GAP;
            req_d   = 1'b0;
            sel_d   = '0;
            gap_d   = '0;
          end else if (enable) begin
            sel_d = sel_q + 3'd1;
          end else begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            sel_d   = '0;
          end
        end else if (req_q) begin
          wait_d = wait_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_SCAN;
          req_d   = 1'b1;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fault_d = (fault_q & ~(hit & {5{xfer}})) | (hit & {5{tmo}});
    gi_d    = gi_q;
    if (xfer && (sel_q == CH_GLYCEMIC)) gi_d = glycemicIndex;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      sel_q   <= '0;
      done_q  <= 1'b0;
      wait_q  <= '0;
      gap_q   <= '0;
      fault_q <= '0;
      gi_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      wait_q  <= wait_d;
      gap_q   <= gap_d;
      fault_q <= fault_d;
      gi_q    <= gi_d;
    end
  end

  for (genvar g = 0; g < 5; g++) begin : g_filt
    persistence_filter #(
      .PERSIST(PERSIST)
    ) u_filt (
      .clk            (clk),
      .rst_n          (rst_n),
      .sample_valid_i (xfer && hit[g]),
      .abnormal_i     (abn[g]),
      .ack_i          (alarmAck),
      .alarm_o        (alarm_vec[g])
    );
  end

  assign sensorReq       = req_q;
  assign sensorSel       = sel_q;
  assign scanDone        = done_q;
  assign sensorFault     = fault_q;
  assign glycemicLatched = gi_q;
  assign alarmVector     = alarm_vec;
  assign alarmActive     = |alarm_vec;
  assign alarmCode       = alarm_code(alarm_vec);

endmodule

// File: tb/tb_health_monitor_scheduler.sv
module tb_health_monitor_scheduler;

  localparam int unsigned GAP = 16;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       sensorReq;
  logic [2:0] sensorSel;
  logic       sensorAck;
  logic       p_ab, b_ab, tl_ab, th_ab, f_ab;
  logic [3:0] gi;
  logic       alarmAck;
  logic [4:0] alarmVector;
  logic       alarmActive;
  logic [2:0] alarmCode;
  logic [4:0] sensorFault;
  logic [3:0] glycemicLatched;
  logic       scanDone;

  logic       ack_en;
  logic       stall_on;
  logic [2:0] stall_ch;

  int n_checks = 0;
  int n_fail   = 0;

  health_monitor_scheduler #(
    .PERSIST    (3),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (8),
    .GI_HIGH    (10)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enable              (enable),
    .sensorReq           (sensorReq),
    .sensorSel           (sensorSel),
    .sensorAck           (sensorAck),
    .presureAbnormality  (p_ab),
    .bloodAbnormality    (b_ab),
    .lowTempAbnormality  (tl_ab),
    .highTempAbnormality (th_ab),
    .fallDetected        (f_ab),
    .glycemicIndex       (gi),
    .alarmAck            (alarmAck),
    .alarmVector         (alarmVector),
    .alarmActive         (alarmActive),
    .alarmCode           (alarmCode),
    .sensorFault         (sensorFault),
    .glycemicLatched     (glycemicLatched),
    .scanDone            (scanDone)
  );

  assign sensorAck = ack_en && !(stall_on && (sensorSel == stall_ch));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One scan round: flags held for the round, optional alarmAck pulsed in the
  // gap before it, optional ch2 stall, and the hand-computed state at scanDone.
  typedef struct packed {
    logic       p, b, tl, th, f;
    logic [3:0] gi;
    logic       ack, stall;
    logic [4:0] av;
    logic [2:0] code;
    logic [4:0] fault;
    logic [3:0] gil;
    logic [4:0] len, xf, sum;
  } round_t;

  round_t rounds [19];
  round_t sb [$];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares round results at every scanDone and measures gap length.
  int unsigned scan_cyc, xfers, selsum, gap_cnt;
  logic        in_gap;
  round_t      e;

  always @(negedge clk) begin
    if (!rst_n) begin
      scan_cyc = 0; xfers = 0; selsum = 0; in_gap = 1'b0; gap_cnt = 0;
    end else begin
      if (in_gap) begin
        if (sensorReq) begin
          check("gap_len", gap_cnt, GAP);
          in_gap = 1'b0;
        end else begin
          gap_cnt++;
        end
      end
      if (sensorReq) begin
        scan_cyc++;
        if (sensorAck) begin
          xfers++;
          selsum += 32'(sensorSel);
        end
      end
      if (scanDone) begin
        if (sb.size() == 0) begin
          check("unexpected_scanDone", 1, 0);
        end else begin
          e = sb.pop_front();
          check("alarmVector", alarmVector, e.av);
          check("alarmActive", alarmActive, 32'(|e.av));
          check("alarmCode", alarmCode, e.code);
          check("sensorFault", sensorFault, e.fault);
          check("glycemicLatched", glycemicLatched, e.gil);
          check("scan_len", scan_cyc, e.len);
          check("xfer_count", xfers, e.xf);
          check("sel_sum", selsum, e.sum);
        end
        scan_cyc = 0; xfers = 0; selsum = 0;
        in_gap = 1'b1; gap_cnt = 1;
      end
    end
  end

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (scanDone) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_sel(input logic [2:0] ch, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sensorReq && sensorSel == ch) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    //             p b tl th f  gi  ack st  av     code  fault  gil  len xf sum
    rounds[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 1'b0,1'b0,5'h00,3'd7,5'h00,4'd0, 5'd5, 5'd5,5'd10};
    rounds[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'd0, 1'b0,1'b0,5'h00,3'd7,5'h00,4'd0, 5'd5, 5'd5,5'd10};
    rounds[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'd0, 1'b0,1'b0,5'h00,3'd7,5'h00,4'd0, 5'd5, 5'd5,5'd10};
    rounds[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'd0, 1'b0,1'b0,5'h01,3'd0,5'h00,4'd0, 5'd5, 5'd5,5'd10};
    rounds[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 1'b0,1'b0,5'h01,3'd0,5'h00,4'd0, 5'd5, 5'd5,5'd10};
    rounds[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'd0, 1'b1,1'b0,5'h00,3'd7,5'h00,4'd0, 5'd5, 5'd5,5'd10};
    rounds[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'd0, 1'b0,1'b0,5'h00,3'd7,5'h00,4'd0, 5'd5, 5'd5,5'd10};
    rounds[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 1'b0,1'b0,5'h00,3'd7,5'h00,4'd0, 5'd5, 5'd5,5'd10};
    rounds[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,4'd0, 1'b0,1'b0,5'h00,3'd7,5'h00,4'd0, 5'd5, 5'd5,5'd10};
    rounds[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,4'd0, 1'b0,1'b0,5'h00,3'd7,5'h00,4'd0, 5'd5, 5'd5,5'd10};
    rounds[10] = '{1'b0,1'b1,1'b0,1'b0,1'b1,4'd0, 1'b0,1'b0,5'h0A,3'd3,5'h00,4'd0, 5'd5, 5'd5,5'd10};
    rounds[11] = '{1'b0,1'b1,1'b0,1'b0,1'b1,4'd0, 1'b1,1'b0,5'h0A,3'd3,5'h00,4'd0, 5'd5, 5'd5,5'd10};
    rounds[12] = '{1'b0,1'b1,1'b0,1'b0,1'b0,4'd0, 1'b0,1'b0,5'h0A,3'd3,5'h00,4'd0, 5'd5, 5'd5,5'd10};
    rounds[13] = '{1'b0,1'b1,1'b0,1'b0,1'b0,4'd0, 1'b1,1'b0,5'h02,3'd1,5'h00,4'd0, 5'd5, 5'd5,5'd10};
    rounds[14] = '{1'b0,1'b0,1'b1,1'b0,1'b0,4'd10,1'b0,1'b1,5'h02,3'd1,5'h04,4'd10,5'd12,5'd4,5'd8};
    rounds[15] = '{1'b0,1'b0,1'b1,1'b0,1'b0,4'd10,1'b1,1'b0,5'h00,3'd7,5'h00,4'd10,5'd5, 5'd5,5'd10};
    rounds[16] = '{1'b0,1'b0,1'b0,1'b1,1'b0,4'd10,1'b0,1'b0,5'h10,3'd4,5'h00,4'd10,5'd5, 5'd5,5'd10};
    rounds[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'd9, 1'b0,1'b0,5'h10,3'd4,5'h00,4'd9, 5'd5, 5'd5,5'd10};
    rounds[18] = '{1'b0,1'b0,1'b0,1'b0,1'b0,4'd9, 1'b1,1'b0,5'h00,3'd7,5'h00,4'd9, 5'd5, 5'd5,5'd10};

    rst_n = 1'b0; enable = 1'b0; alarmAck = 1'b0;
    p_ab = 1'b0; b_ab = 1'b0; tl_ab = 1'b0; th_ab = 1'b0; f_ab = 1'b0; gi = '0;
    ack_en = 1'b1; stall_on = 1'b0; stall_ch = 3'd2;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_sensorReq", sensorReq, 0);
    check("rst_sensorSel", sensorSel, 0);
    check("rst_scanDone", scanDone, 0);
    check("rst_alarmVector", alarmVector, 0);
    check("rst_alarmCode", alarmCode, 7);
    check("rst_sensorFault", sensorFault, 0);
    check("rst_glycemicLatched", glycemicLatched, 0);

    for (int r = 0; r < 19; r++) begin
      p_ab = rounds[r].p; b_ab = rounds[r].b; tl_ab = rounds[r].tl;
      th_ab = rounds[r].th; f_ab = rounds[r].f; gi = rounds[r].gi;
      stall_on = rounds[r].stall; stall_ch = 3'd2;
      if (rounds[r].ack) begin
        alarmAck = 1'b1;
        @(negedge clk);
        alarmAck = 1'b0;
      end
      sb.push_back(rounds[r]);
      enable = 1'b1;
      wait_done(ok);
      if (!ok) check("round_scanDone_timeout", 0, 1);
    end

    // Drop enable while ch1 is pending: ch1 completes, then IDLE, no scanDone.
    p_ab = 1'b0; b_ab = 1'b0; tl_ab = 1'b0; th_ab = 1'b0; f_ab = 1'b0;
    stall_ch = 3'd1; stall_on = 1'b1;
    wait_sel(3'd1, ok);
    if (!ok) check("wait_ch1_timeout", 0, 1);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("pending_ch1_req", sensorReq, 1);
    stall_on = 1'b0;
    @(negedge clk);
    check("idle_sensorReq", sensorReq, 0);
    check("idle_sensorSel", sensorSel, 0);
    check("idle_scanDone", scanDone, 0);
    repeat (20) @(negedge clk);
    check("idle_stays", sensorReq, 0);
    check("idle_glycemic_kept", glycemicLatched, 9);

    // Async reset mid-scan.
    enable = 1'b1;
    wait_sel(3'd2, ok);
    if (!ok) check("wait_ch2_timeout", 0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sensorReq", sensorReq, 0);
    check("async_rst_sensorSel", sensorSel, 0);
    check("async_rst_glycemic", glycemicLatched, 0);
    check("async_rst_alarmCode", alarmCode, 7);
    check("async_rst_fault", sensorFault, 0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
